// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulate stage.
package mac_pkg;

  localparam int unsigned DEF_PROD_W = 32;
  localparam int unsigned DEF_ACC_W  = 40;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_sat_add.sv
// Unsigned accumulator add: zero-extends the product and clamps to all ones on carry out.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] total;

  // ACC_W+1-bit sum; the extra bit is the saturation flag
  always_comb begin
    prod_ext               = '0;
    prod_ext[PROD_W-1:0]   = prod;
    total                  = {1'b0, acc} + prod_ext;
    sat                    = total[ACC_W];
    sum                    = sat ? '1 : total[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulate stage: sums len products per job into a saturating
// accumulator and holds the result until the consumer takes it.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_sum;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovf_q;
  logic               add_sat;
  logic               job_start;
  logic               beat;
  logic               last_beat;

  mac_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc  (acc_q),
    .prod (prod),
    .sum  (acc_sum),
    .sat  (add_sat)
  );

  // Handshake qualifiers; ready is implied by the ACCUM state
  always_comb begin
    job_start = (state_q == ST_IDLE) && start && (len != '0);
    beat      = (state_q == ST_ACCUM) && prod_valid;
    last_beat = beat && (cnt_q == (len_q - LEN_W'(1)));
  end

  // Next-state logic; clr overrides everything
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (job_start) state_d = ST_ACCUM;
        ST_ACCUM: if (last_beat) state_d = ST_DONE;
        ST_DONE:  if (res_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Accumulator, beat counter, job length and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (job_start) begin
      len_q <= len;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + LEN_W'(1);
      if (add_sat) ovf_q <= 1'b1;
    end
  end

  // Output decode from registered state only
  always_comb begin
    prod_ready = (state_q == ST_ACCUM);
    res_valid  = (state_q == ST_DONE);
    res        = res_valid ? acc_q : '0;
    ovf        = ovf_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: two instances (40-bit and 34-bit
// accumulators) share stimulus; a reference model predicts each job result.
module tb_mac_accumulator;

  localparam longint unsigned MAX40 = (64'd1 << 40) - 64'd1;
  localparam longint unsigned MAX34 = (64'd1 << 34) - 64'd1;

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        res_ready = 1'b0;

  logic        pr40, rv40, ovf40, busy40;
  logic        pr34, rv34, ovf34, busy34;
  logic [39:0] res40;
  logic [33:0] res34;

  int tests = 0;
  int fails = 0;

  exp_t q40[$];
  exp_t q34[$];
  logic [31:0] pv [256];

  mac_accumulator d40 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(pr40),
    .res(res40), .res_valid(rv40), .res_ready(res_ready),
    .ovf(ovf40), .busy(busy40)
  );

  mac_accumulator #(.ACC_W(34)) d34 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(pr34),
    .res(res34), .res_valid(rv34), .res_ready(res_ready),
    .ovf(ovf34), .busy(busy34)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result handshake is about to happen
  always @(negedge clk) begin
    exp_t e;
    if (rv40 && res_ready) begin
      if (q40.size() == 0) chk("unexpected_res40", 64'd1, 64'd0);
      else begin
        e = q40.pop_front();
        chk("res40", 64'(res40), e.res);
        chk("ovf40", 64'(ovf40), 64'(e.ovf));
      end
    end
    if (rv34 && res_ready) begin
      if (q34.size() == 0) chk("unexpected_res34", 64'd1, 64'd0);
      else begin
        e = q34.pop_front();
        chk("res34", 64'(res34), e.res);
        chk("ovf34", 64'(ovf34), 64'(e.ovf));
      end
    end
    if (!rv40) chk("res40_zero_not_done", 64'(res40), 64'd0);
    if (!rv34) chk("res34_zero_not_done", 64'(res34), 64'd0);
  end

  // One job: model predicts result from plain sums, pushes it, then drives the beats
  task automatic run_job(input int unsigned n, input int unsigned vpct,
                         input bit alt, input int unsigned hold);
    longint unsigned total;
    exp_t e40, e34;
    int unsigned i, budget;
    logic b;
    total = 0;
    for (int unsigned k = 0; k < n; k++) total += 64'(pv[k]);
    e40.res = (total > MAX40) ? MAX40 : total;
    e40.ovf = (total > MAX40);
    e34.res = (total > MAX34) ? MAX34 : total;
    e34.ovf = (total > MAX34);
    q40.push_back(e40);
    q34.push_back(e34);

    start = 1'b1; len = 8'(n);
    @(posedge clk); #1;
    start = 1'b0; len = 8'($urandom);
    chk("busy_after_start", {busy40, busy34}, 2'b11);

    i = 0; budget = 0;
    while (i < n && budget < 4000) begin
      prod_valid = alt ? (budget % 2 == 0) : ($urandom_range(99) < vpct);
      prod = prod_valid ? pv[i] : $urandom;
      @(negedge clk);
      chk("prod_ready_accum", {pr40, pr34}, 2'b11);
      b = prod_valid && pr40;
      @(posedge clk); #1;
      if (b) i++;
      budget++;
    end
    prod_valid = 1'b0; prod = $urandom;
    if (i < n) chk("beat_timeout", 64'(i), 64'(n));
    chk("latency_res_valid", {rv40, rv34, pr40, pr34}, 4'b1100);

    for (int unsigned h = 0; h < hold; h++) begin
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      chk("hold_res40", 64'(res40), e40.res);
      chk("hold_res34", 64'(res34), e34.res);
      chk("hold_ovf", {ovf40, ovf34}, {e40.ovf, e34.ovf});
      chk("hold_valid_noready", {rv40, rv34, pr40, pr34}, 4'b1100);
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_pop", {busy40, busy34, rv40, rv34}, 4'b0000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_outputs", {busy40, busy34, rv40, rv34, pr40, pr34, ovf40, ovf34}, 8'h00);
    chk("reset_res", 64'(res40) | 64'(res34), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic sum with result one cycle after last beat
    pv[0] = 32'd1; pv[1] = 32'd2; pv[2] = 32'd3; pv[3] = 32'd4;
    run_job(4, 100, 1'b0, 0);

    // gapped valid: only accepted beats count
    for (int k = 0; k < 3; k++) pv[k] = 32'hFFFE_0001;
    run_job(3, 0, 1'b1, 1);

    // saturation in the narrow instance, then a clean job clears ovf
    for (int k = 0; k < 5; k++) pv[k] = 32'hFFFF_FFFF;
    run_job(5, 100, 1'b0, 0);
    pv[0] = 32'd7;
    run_job(1, 100, 1'b0, 0);

    // long hold with start poked during DONE, then len=0 start ignored
    pv[0] = 32'd100; pv[1] = 32'd200;
    run_job(2, 100, 1'b0, 10);
    start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_ignored", {busy40, busy34}, 2'b00);

    // clr after two beats drops the in-flight beat and aborts
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      prod_valid = 1'b1; prod = $urandom;
      @(posedge clk); #1;
    end
    clr = 1'b1; prod = 32'h1234_5678;
    @(posedge clk); #1;
    clr = 1'b0; prod_valid = 1'b0;
    chk("clr_idle", {busy40, busy34, rv40, rv34, pr40, pr34}, 6'b000000);
    pv[0] = 32'd5; pv[1] = 32'd6;
    run_job(2, 100, 1'b0, 0);

    // async reset mid-job clears outputs before the next edge
    start = 1'b1; len = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      prod_valid = 1'b1; prod = $urandom;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {busy40, busy34, rv40, rv34, pr40, pr34, ovf40, ovf34}, 8'h00);
    chk("async_rst_res", 64'(res40) | 64'(res34), 64'd0);
    prod_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pv[0] = 32'd9;
    run_job(1, 100, 1'b0, 0);

    // randomized jobs, including one long saturating job
    for (int j = 0; j < 25; j++) begin
      int unsigned n;
      n = (j == 12) ? 255 : $urandom_range(24, 1);
      for (int k = 0; k < 256; k++) begin
        case ($urandom_range(3))
          0:       pv[k] = 32'hFFFF_FFFF;
          1:       pv[k] = 32'($urandom_range(255));
          default: pv[k] = $urandom;
        endcase
      end
      run_job(n, $urandom_range(100, 40), 1'b0, $urandom_range(4));
      if ($urandom_range(1)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q40.size() + q34.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
